// File: rtl/dmem_access_pkg.sv
// Shared types and constants for the data-memory load/store sequencer.
package dmem_access_pkg;

  // Sequencer phases: waiting for an operation, requesting memory, completing.
  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_REQ  = 2'd1,
    DMA_DONE = 2'd2
  } dma_state_t;

  // REQ cycles without ack before the operation is abandoned.
  localparam int DMA_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/data_mem_access_unit.sv
// Load/store sequencer between the register file and data memory.
// Captures DMAR/ACC on accept, runs a req/ack handshake with a memory of
// unknown latency, and returns load data as a one-cycle ACC write pulse.
// A REQ phase that waits TIMEOUT_CYC cycles without ack is abandoned and
// flagged through the sticky timeout_err output.
module data_mem_access_unit
  import dmem_access_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int D_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYC  = DMA_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    op_valid,
  input  logic                    op_is_store,
  output logic                    op_ready,
  input  logic [D_ADDR_WIDTH-1:0] dmar,
  input  logic [DATA_W-1:0]       acc_out,
  output logic [DATA_W-1:0]       load_data,
  output logic                    load_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [D_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    err_clear
);

  // A zero timeout disables the abort; keep the counter one bit wide then.
  localparam int              CNT_W      = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  dma_state_t              state;
  dma_state_t              state_next;
  logic [CNT_W-1:0]        timeout_cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic                    req_next;
  logic                    we_next;
  logic [D_ADDR_WIDTH-1:0] addr_next;
  logic [DATA_W-1:0]       wdata_next;
  logic [DATA_W-1:0]       ld_next;
  logic                    lv_next;
  logic                    timeout_set;
  logic                    terr_next;
  logic                    ready_next;
  logic                    busy_next;

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_next  = state;
    cnt_next    = timeout_cnt;
    req_next    = 1'b0;
    we_next     = mem_we;
    addr_next   = mem_addr;
    wdata_next  = mem_wdata;
    ld_next     = load_data;
    lv_next     = 1'b0;
    timeout_set = 1'b0;

    case (state)
      DMA_IDLE: begin
        if (op_valid && op_ready) begin
          addr_next  = dmar;
          wdata_next = acc_out;
          we_next    = op_is_store;
          cnt_next   = '0;
          req_next   = 1'b1;
          state_next = DMA_REQ;
        end else begin
          state_next = DMA_IDLE;
        end
      end

      DMA_REQ: begin
        if (mem_ack) begin
          // Stores complete silently; loads latch data and pulse load_valid.
          if (!mem_we) begin
            ld_next = mem_rdata;
            lv_next = 1'b1;
          end else begin
            lv_next = 1'b0;
          end
          state_next = DMA_DONE;
        end else if (TIMEOUT_EN && (timeout_cnt == CNT_LAST)) begin
          // Counter saturates at the abort point rather than wrapping.
          cnt_next    = CNT_MAX;
          timeout_set = 1'b1;
          state_next  = DMA_DONE;
        end else begin
          if (TIMEOUT_EN) begin
            cnt_next = timeout_cnt + CNT_ONE;
          end else begin
            cnt_next = timeout_cnt;
          end
          req_next   = 1'b1;
          state_next = DMA_REQ;
        end
      end

      DMA_DONE: begin
        cnt_next   = '0;
        state_next = DMA_IDLE;
      end

      default: begin
        cnt_next   = '0;
        state_next = DMA_IDLE;
      end
    endcase

    // A timeout raised in the same cycle as err_clear keeps the flag set.
    if (timeout_set) begin
      terr_next = 1'b1;
    end else if (err_clear) begin
      terr_next = 1'b0;
    end else begin
      terr_next = timeout_err;
    end

    ready_next = (state_next == DMA_IDLE);
    busy_next  = (state_next != DMA_IDLE);
  end

  // State, counter and output registers; reset drops mem_req immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= DMA_IDLE;
      timeout_cnt <= '0;
      op_ready    <= 1'b1;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      timeout_cnt <= cnt_next;
      op_ready    <= ready_next;
      busy        <= busy_next;
      mem_req     <= req_next;
      mem_we      <= we_next;
      mem_addr    <= addr_next;
      mem_wdata   <= wdata_next;
      load_data   <= ld_next;
      load_valid  <= lv_next;
      timeout_err <= terr_next;
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Randomized and directed bench for data_mem_access_unit. Two instances share
// all inputs: one with an 8-cycle timeout, one with the timeout disabled.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_is_store = 1'b0;
  logic [11:0] dmar = 12'd0;
  logic [7:0]  acc_out = 8'd0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        mem_ack = 1'b0;
  logic        err_clear = 1'b0;

  logic        op_ready_a, load_valid_a, mem_req_a, mem_we_a, busy_a, timeout_err_a;
  logic [7:0]  load_data_a, mem_wdata_a;
  logic [11:0] mem_addr_a;
  logic        op_ready_b, load_valid_b, mem_req_b, mem_we_b, busy_b, timeout_err_b;
  logic [7:0]  load_data_b, mem_wdata_b;
  logic [11:0] mem_addr_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_access_unit #(.DATA_W(8), .D_ADDR_WIDTH(12), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_is_store(op_is_store),
    .op_ready(op_ready_a), .dmar(dmar), .acc_out(acc_out), .load_data(load_data_a),
    .load_valid(load_valid_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy_a), .timeout_err(timeout_err_a), .err_clear(err_clear)
  );

  data_mem_access_unit #(.DATA_W(8), .D_ADDR_WIDTH(12), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_is_store(op_is_store),
    .op_ready(op_ready_b), .dmar(dmar), .acc_out(acc_out), .load_data(load_data_b),
    .load_valid(load_valid_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy_b), .timeout_err(timeout_err_b), .err_clear(err_clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding operation per instance, tracked as
  // "waiting for memory" then "finishing" with its captured operands.
  int          tcyc [2] = '{8, 0};
  bit          m_idle [2] = '{1'b1, 1'b1};
  bit          m_wait_mem [2] = '{1'b0, 1'b0};
  bit          m_finish [2] = '{1'b0, 1'b0};
  bit          m_lv [2] = '{1'b0, 1'b0};
  bit          m_we [2] = '{1'b0, 1'b0};
  bit          m_terr [2] = '{1'b0, 1'b0};
  logic [7:0]  m_ld [2] = '{8'd0, 8'd0};
  logic [7:0]  m_wd [2] = '{8'd0, 8'd0};
  logic [11:0] m_addr [2] = '{12'd0, 12'd0};
  int          m_waited [2] = '{0, 0};

  // Model update at each clock edge; reset clears it asynchronously.
  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_idle[i] <= 1'b1; m_wait_mem[i] <= 1'b0; m_finish[i] <= 1'b0;
        m_lv[i] <= 1'b0; m_we[i] <= 1'b0; m_terr[i] <= 1'b0;
        m_ld[i] <= 8'd0; m_wd[i] <= 8'd0; m_addr[i] <= 12'd0; m_waited[i] <= 0;
      end else begin
        m_lv[i] <= 1'b0;
        if (err_clear) m_terr[i] <= 1'b0;
        if (m_finish[i]) begin
          m_finish[i] <= 1'b0;
          m_idle[i]   <= 1'b1;
        end else if (m_wait_mem[i]) begin
          if (mem_ack) begin
            if (!m_we[i]) begin
              m_ld[i] <= mem_rdata;
              m_lv[i] <= 1'b1;
            end
            m_wait_mem[i] <= 1'b0;
            m_finish[i]   <= 1'b1;
          end else if (tcyc[i] != 0 && m_waited[i] + 1 == tcyc[i]) begin
            m_wait_mem[i] <= 1'b0;
            m_finish[i]   <= 1'b1;
            m_terr[i]     <= 1'b1;
          end else begin
            m_waited[i] <= m_waited[i] + 1;
          end
        end else if (op_valid) begin
          m_idle[i] <= 1'b0; m_wait_mem[i] <= 1'b1; m_waited[i] <= 0;
          m_addr[i] <= dmar; m_wd[i] <= acc_out; m_we[i] <= op_is_store;
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input logic rdy, input logic bsy, input logic req,
                         input logic we, input logic lv, input logic terr,
                         input logic [11:0] addr, input logic [7:0] wd, input logic [7:0] ld);
    check($sformatf("d%0d_op_ready", d), 32'(rdy), 32'(m_idle[d]));
    check($sformatf("d%0d_busy", d), 32'(bsy), 32'(!m_idle[d]));
    check($sformatf("d%0d_mem_req", d), 32'(req), 32'(m_wait_mem[d]));
    check($sformatf("d%0d_load_valid", d), 32'(lv), 32'(m_lv[d]));
    check($sformatf("d%0d_timeout_err", d), 32'(terr), 32'(m_terr[d]));
    check($sformatf("d%0d_load_data", d), 32'(ld), 32'(m_ld[d]));
    if (m_wait_mem[d]) begin
      check($sformatf("d%0d_mem_we", d), 32'(we), 32'(m_we[d]));
      check($sformatf("d%0d_mem_addr", d), 32'(addr), 32'(m_addr[d]));
      check($sformatf("d%0d_mem_wdata", d), 32'(wd), 32'(m_wd[d]));
    end
  endtask

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    cmp_dut(0, op_ready_a, busy_a, mem_req_a, mem_we_a, load_valid_a, timeout_err_a,
            mem_addr_a, mem_wdata_a, load_data_a);
    cmp_dut(1, op_ready_b, busy_b, mem_req_b, mem_we_b, load_valid_b, timeout_err_b,
            mem_addr_b, mem_wdata_b, load_data_b);
  end

  // Present one operation for a single cycle; returns in the first REQ cycle.
  task automatic issue(input logic st, input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    op_valid = 1'b1; op_is_store = st; dmar = a; acc_out = d;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  int n;
  int acc_k[$];

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_op_ready", 32'(op_ready_a), 32'd1);
    check("rst_mem_req", 32'(mem_req_a), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: load with immediate ack
    issue(1'b0, 12'h3A5, 8'h00);
    check("t1_req", 32'(mem_req_a), 32'd1);
    check("t1_addr", 32'(mem_addr_a), 32'h3A5);
    mem_ack = 1'b1; mem_rdata = 8'h5C;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t1_lv", 32'(load_valid_a), 32'd1);
    check("t1_ld", 32'(load_data_a), 32'h5C);
    check("t1_req_off", 32'(mem_req_a), 32'd0);
    @(negedge clk);
    check("t1_ready", 32'(op_ready_a), 32'd1);
    check("t1_lv_off", 32'(load_valid_a), 32'd0);

    // 2: store acked after 4 wait cycles
    issue(1'b1, 12'h123, 8'hA7);
    for (int k = 0; k < 5; k++) begin
      check("t2_req", 32'(mem_req_a), 32'd1);
      check("t2_we", 32'(mem_we_a), 32'd1);
      check("t2_wdata", 32'(mem_wdata_a), 32'hA7);
      check("t2_addr", 32'(mem_addr_a), 32'h123);
      mem_ack = (k == 4);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("t2_no_lv", 32'(load_valid_a), 32'd0);
    @(negedge clk);

    // 3: load timeout on the 8-cycle instance; disabled instance keeps waiting
    issue(1'b0, 12'h0F0, 8'h00);
    n = 0;
    while (mem_req_a && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t3_req_cycles", 32'(n), 32'd8);
    check("t3_terr", 32'(timeout_err_a), 32'd1);
    check("t3_no_lv", 32'(load_valid_a), 32'd0);
    check("t3_b_still_req", 32'(mem_req_b), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h33;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t3_b_lv", 32'(load_valid_b), 32'd1);
    check("t3_b_ld", 32'(load_data_b), 32'h33);
    check("t3_a_ld_kept", 32'(load_data_a), 32'h5C);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("t3_cleared", 32'(timeout_err_a), 32'd0);

    // 4: stray acks in IDLE, then back-to-back loads with op_valid held
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    check("t4_stray_lv", 32'(load_valid_a), 32'd0);
    check("t4_stray_ld", 32'(load_data_a), 32'h5C);
    check("t4_stray_ready", 32'(op_ready_a), 32'd1);
    op_valid = 1'b1; op_is_store = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (op_ready_a) acc_k.push_back(k);
      dmar = 12'($urandom); mem_rdata = 8'($urandom);
      @(negedge clk);
    end
    op_valid = 1'b0; mem_ack = 1'b0;
    check("t4_accepts", 32'(acc_k.size()), 32'd3);
    if (acc_k.size() == 3) begin
      check("t4_acc1", 32'(acc_k[1]), 32'd3);
      check("t4_acc2", 32'(acc_k[2]), 32'd6);
    end
    @(negedge clk);

    // 5: reset during REQ
    issue(1'b0, 12'h777, 8'h00);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_req_drop", 32'(mem_req_a), 32'd0);
    check("t5_ready", 32'(op_ready_a), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_lv", 32'(load_valid_a), 32'd0);
    end

    // 6: 300-cycle ack delay; disabled timeout completes normally
    issue(1'b0, 12'hABC, 8'h00);
    for (int k = 0; k < 300; k++) @(negedge clk);
    check("t6_a_terr", 32'(timeout_err_a), 32'd1);
    check("t6_b_req", 32'(mem_req_b), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h96;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t6_b_lv", 32'(load_valid_b), 32'd1);
    check("t6_b_ld", 32'(load_data_b), 32'h96);
    check("t6_b_terr", 32'(timeout_err_b), 32'd0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      op_valid    = ($urandom_range(1, 0) == 1);
      op_is_store = ($urandom_range(1, 0) == 1);
      dmar        = 12'($urandom);
      acc_out     = 8'($urandom);
      mem_rdata   = 8'($urandom);
      mem_ack     = ($urandom_range(3, 0) == 0);
      err_clear   = ($urandom_range(15, 0) == 0);
    end
    @(negedge clk);
    op_valid = 1'b0; mem_ack = 1'b0; err_clear = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
